seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller sharing one seven_segment_display decoder among NUM_DIGITS digits.

---
 rtl/seg_scan_pkg.sv | 24 ++
 rtl/seg_scan_ctrl_prescaler.sv | 36 +++
 rtl/seg_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
//   Shared definitions for the seven-segment scan controller:
//   - scan_state_e : SHOW (digit driven) / GUARD (all anodes off)
//   - clog2        : ceiling log2 with a floor of 1, used to size idx and
//                    prescaler registers
//   - DEF_NUM_DIGITS : default digit count
package seg_scan_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    GUARD = 1'b1
  } scan_state_e;

  localparam int DEF_NUM_DIGITS = 4;

  // Bits needed to hold values 0..n-1; never returns less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// scan_prescaler
//   Terminal-count counter. Counts 0..i_limit, flags o_tc while at i_limit,
//   and returns to 0 on i_clr (the owner clears it on every state change,
//   which coincides with o_tc).
// Ports
//   clk     in   board clock
//   rst     in   synchronous active-high reset
//   i_clr   in   synchronous clear (wins over counting)
//   i_limit in   W  terminal value, may change with the owner's state
//   o_cnt   out  W  current count
//   o_tc    out  1  count equals i_limit
module scan_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_limit);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller feeding one shared seven-segment
//   decoder. Each digit is driven for SCAN_DIV cycles, followed by GUARD_CYC
//   cycles with all anodes off. New values are taken through a valid/ready
//   port into a shadow register and copied to the displayed register only at
//   frame boundaries, so a frame never shows a mix of old and new nibbles.
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading-zero digits (all nibbles from i upward are zero,
//   i>0) keep their anode off during their slot. Timing is unchanged.
// Ports
//   clk_50M    in   board clock
//   rst        in   synchronous active-high reset
//   upd_valid  in   new display value offered
//   upd_ready  out  shadow free (= !pending)
//   upd_value  in   4*NUM_DIGITS, nibble i = digit i (digit 0 rightmost)
//   upd_dp     in   NUM_DIGITS decimal-point mask
//   digit_sel  out  NUM_DIGITS one-hot anode enable, zero = blank
//   nibble     out  4 value for the shared decoder
//   dp_out     out  decimal point for the selected digit
//   frame_done out  one-cycle pulse after each frame boundary
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD_CYC  = 2
) (
  input  logic                    clk_50M,
  input  logic                    rst,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_value,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [3:0]              nibble,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int IW = clog2(NUM_DIGITS);
  localparam int PW = clog2((SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC);

  scan_state_e             r_state;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [NUM_DIGITS-1:0]   r_active_dp;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_pending;
  logic [NUM_DIGITS-1:0]   r_digit_sel;
  logic [3:0]              r_nibble;
  logic                    r_dp_out;
  logic                    r_frame_done;

  logic [PW-1:0]           w_limit;
  logic [PW-1:0]           w_cnt;
  logic                    w_tc;
  logic                    w_last;
  logic                    w_boundary;
  logic                    w_xfer;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [NUM_DIGITS-1:0]   w_sel;

  assign w_limit = (r_state == SHOW) ? PW'(SCAN_DIV - 1) : PW'(GUARD_CYC - 1);

  // Single counter serves both states; it wraps exactly when the state flips.
  scan_prescaler #(
    .W(PW)
  ) u_prescaler (
    .clk     (clk_50M),
    .rst     (rst),
    .i_clr   (w_tc),
    .i_limit (w_limit),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  assign w_last     = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_boundary = (r_state == GUARD) && w_tc && w_last;
  assign w_xfer     = upd_valid && !r_pending;

`ifdef LEADING_ZERO_BLANK_EN
  // Scan from the most significant digit down; a digit is blank while every
  // nibble from it upward is zero. Digit 0 is never blanked.
  always_comb begin
    logic w_run;
    w_run   = 1'b1;
    w_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run = w_run && (r_active[4*i +: 4] == 4'd0);
      if (i != 0) w_blank[i] = w_run;
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_sel = w_blank[r_idx] ? '0 : (NUM_DIGITS'(1) << r_idx);

  // Scan FSM, index and registered display outputs
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_state      <= SHOW;
      r_idx        <= '0;
      r_digit_sel  <= '0;
      r_nibble     <= '0;
      r_dp_out     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (r_state == SHOW) begin
        r_digit_sel <= w_sel;
        r_nibble    <= r_active[4*r_idx +: 4];
        r_dp_out    <= r_active_dp[r_idx];
        if (w_tc) r_state <= GUARD;
      end else begin
        // nibble/dp hold so the decoder input stays quiet while anodes are off
        r_digit_sel <= '0;
        if (w_tc) begin
          r_state <= SHOW;
          r_idx   <= w_last ? '0 : r_idx + IW'(1);
        end
      end
    end
  end

  // Update handshake: shadow capture and frame-aligned copy to active.
  // A transfer only happens while pending=0, so it can never collide with a
  // copy (which needs pending=1); a same-cycle boundary copies nothing.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_pending   <= 1'b0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_active    <= '0;
      r_active_dp <= '0;
    end else if (w_xfer) begin
      r_shadow    <= upd_value;
      r_shadow_dp <= upd_dp;
      r_pending   <= 1'b1;
    end else if (w_boundary && r_pending) begin
      r_active    <= r_shadow;
      r_active_dp <= r_shadow_dp;
      r_pending   <= 1'b0;
    end
  end

  assign upd_ready  = !r_pending;
  assign digit_sel  = r_digit_sel;
  assign nibble     = r_nibble;
  assign dp_out     = r_dp_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int GC    = 1;
  localparam int SLOT  = SD + GC;
  localparam int FRAME = ND * SLOT;

  logic          clk_50M = 1'b0;
  logic          rst = 1'b1;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [15:0]   upd_value = '0;
  logic [3:0]    upd_dp = '0;
  logic [3:0]    digit_sel;
  logic [3:0]    nibble;
  logic          dp_out;
  logic          frame_done;

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .GUARD_CYC  (GC)
  ) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_value  (upd_value),
    .upd_dp     (upd_dp),
    .digit_sel  (digit_sel),
    .nibble     (nibble),
    .dp_out     (dp_out),
    .frame_done (frame_done)
  );

  always #5 clk_50M = ~clk_50M;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: time position within the frame plus displayed/offered values
  int          m_pos = 0;
  logic [15:0] m_active = '0;
  logic [3:0]  m_adp = '0;
  logic [15:0] m_shadow = '0;
  logic [3:0]  m_sdp = '0;
  bit          m_pend = 0;
  bit          m_acc = 0;
  logic [3:0]  e_sel = '0;
  logic [3:0]  e_nib = '0;
  logic        e_dp = 1'b0;
  logic        e_fd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit blank(input int d);
`ifdef LEADING_ZERO_BLANK_EN
    return (d > 0) && ((m_active >> (4 * d)) == 16'd0);
`else
    return (d < 0);
`endif
  endfunction

  // One clock: drive inputs, advance model with pre-edge state, check after edge.
  task automatic step(input bit r, input bit v, input logic [15:0] val, input logic [3:0] dpm);
    int d;
    bit show;
    rst = r; upd_valid = v; upd_value = val; upd_dp = dpm;
    m_acc = 0;
    if (r) begin
      m_pos = 0; m_active = '0; m_adp = '0; m_shadow = '0; m_sdp = '0; m_pend = 0;
      e_sel = '0; e_nib = '0; e_dp = 1'b0; e_fd = 1'b0;
    end else begin
      d    = m_pos / SLOT;
      show = (m_pos % SLOT) < SD;
      e_fd = (m_pos == FRAME - 1);
      if (show) begin
        e_sel = blank(d) ? 4'b0000 : (4'b0001 << d);
        e_nib = m_active[4*d +: 4];
        e_dp  = m_adp[d];
      end else begin
        e_sel = 4'b0000;
      end
      m_acc = v && !m_pend;
      if (m_pos == FRAME - 1 && m_pend) begin
        m_active = m_shadow; m_adp = m_sdp; m_pend = 0;
      end
      if (m_acc) begin
        m_shadow = val; m_sdp = dpm; m_pend = 1;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    @(posedge clk_50M);
    #1;
    chk("digit_sel",  {28'd0, digit_sel}, {28'd0, e_sel});
    chk("nibble",     {28'd0, nibble},    {28'd0, e_nib});
    chk("dp_out",     {31'd0, dp_out},    {31'd0, e_dp});
    chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
    chk("upd_ready",  {31'd0, upd_ready}, {31'd0, !m_pend});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0);
  endtask

  // Offer a value with valid held until accepted (bounded).
  task automatic offer(input logic [15:0] val, input logic [3:0] dpm);
    int k;
    k = 0;
    do begin
      step(0, 1, val, dpm);
      k++;
    end while (!m_acc && k < 4 * FRAME);
    chk("offer_accepted", {31'd0, m_acc}, 32'd1);
  endtask

  int lowcnt;
  int k;
  int fd_gap;
  int fd_last;

  initial begin
    // Reset and free-running scan
    step(1, 0, '0, '0);
    step(1, 1, 16'hFFFF, 4'hF);
    fd_last = -1;
    fd_gap  = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(0, 0, '0, '0);
      if (frame_done) begin
        if (fd_last >= 0) fd_gap = i - fd_last;
        fd_last = i;
      end
    end
    chk("frame_period", fd_gap, FRAME);

    // Handshake with 1234 / dp 0100
    offer(16'h1234, 4'b0100);
    idle(2 * FRAME);

    // Back-to-back offers, second waits for ready
    offer(16'hAAAA, 4'b0001);
    offer(16'h5555, 4'b1000);
    idle(2 * FRAME);

    // Transfer in the boundary cycle with pending=0
    k = 0;
    while (!(m_pos == FRAME - 1 && !m_pend) && k < 3 * FRAME) begin
      step(0, 0, '0, '0);
      k++;
    end
    chk("reach_boundary", {31'd0, (m_pos == FRAME - 1)}, 32'd1);
    step(0, 1, 16'h0987, 4'b0010);
    chk("boundary_accept", {31'd0, m_acc}, 32'd1);
    lowcnt = (upd_ready == 1'b0) ? 1 : 0;
    for (int i = 0; i < FRAME + 5; i++) begin
      step(0, 0, '0, '0);
      if (upd_ready == 1'b0) lowcnt++;
    end
    chk("ready_low_len", lowcnt, FRAME);

    // Reset in GUARD with an update pending
    offer(16'hBEEF, 4'b1111);
    k = 0;
    while (!((m_pos % SLOT) == SD && m_pend) && k < 3 * FRAME) begin
      step(0, 0, '0, '0);
      k++;
    end
    chk("reach_guard_pending", {31'd0, m_pend}, 32'd1);
    step(1, 0, '0, '0);
    idle(2 * FRAME + 3);

    // Leading-zero case
    offer(16'h0070, 4'b0000);
    idle(2 * FRAME);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
           16'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
